// File: rtl/axis_i2s_pkg.sv
// Shared definitions for the I2S DAC datapath: FSM encodings and stereo half-width.
package axis_i2s_pkg;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int I2S_DATA_WIDTH = 16;

endpackage

// File: rtl/axis_i2s_dac_buffer_ram.sv
// Simple dual-port sample store: one write port and one registered read port on a single clock.
module axis_i2s_dac_buffer_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Storage array, left unreset so it maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read register; the reset only forces the visible output to zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_data <= {DATA_WIDTH{1'b0}};
    end else begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/axis_i2s_dac_buffer.sv
// Prefill FIFO between an AXI4-Stream host and an I2S DAC serializer.
// Optional underrun counter on sts_underrun when AXIS_I2S_DAC_BUFFER_UNDERRUN_EN is defined.
module axis_i2s_dac_buffer
  import axis_i2s_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 2 * I2S_DATA_WIDTH,
  parameter int ADDR_WIDTH       = 9
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [ADDR_WIDTH:0]         cfg_data,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic [ADDR_WIDTH:0]         sts_data
`ifdef AXIS_I2S_DAC_BUFFER_UNDERRUN_EN
  ,
  output logic [31:0]                 sts_underrun
`endif
);

  localparam logic [ADDR_WIDTH:0] ZERO  = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_WIDTH:0] r_wr_ptr;
  logic [ADDR_WIDTH:0] r_wr_ptr_d;
  logic [ADDR_WIDTH:0] r_rd_ptr;
  logic [ADDR_WIDTH:0] r_count;
  logic                r_s_tready;
  logic [ADDR_WIDTH:0] w_rd_ptr_next;
  logic [ADDR_WIDTH:0] w_count_next;
  logic [ADDR_WIDTH:0] w_level;
  logic                w_wr;
  logic                w_pop;
  logic                w_underrun;

  // A pop frees a slot in the same cycle, so a full buffer still accepts a concurrent write.
  assign w_pop         = m_axis_tready & m_axis_tvalid;
  assign s_axis_tready = r_s_tready | w_pop;
  assign w_wr          = s_axis_tvalid & s_axis_tready;
  // The delayed write pointer hides a sample until the RAM read register has caught up with it.
  assign m_axis_tvalid = (r_state == RUN) & (r_wr_ptr_d != r_rd_ptr);
  assign w_underrun    = (r_state == RUN) & m_axis_tready & (r_count == ZERO);
  assign w_rd_ptr_next = w_pop ? (r_rd_ptr + ONE) : r_rd_ptr;
  assign sts_data      = r_count;

  // Effective prefill level clamped into 1..depth.
  always_comb begin
    w_level = cfg_data;
    if (cfg_data == ZERO) begin
      w_level = ONE;
    end else if (cfg_data > DEPTH) begin
      w_level = DEPTH;
    end else begin
      w_level = cfg_data;
    end
  end

  // Fill count update from the write/pop pair.
  always_comb begin
    w_count_next = r_count;
    case ({w_wr, w_pop})
      2'b10:   w_count_next = r_count + ONE;
      2'b01:   w_count_next = r_count - ONE;
      default: w_count_next = r_count;
    endcase
  end

  // FILL/RUN next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FILL: begin
        if (r_count >= w_level) begin
          w_state_next = RUN;
        end else begin
          w_state_next = FILL;
        end
      end
      RUN: begin
        if (w_underrun) begin
          w_state_next = FILL;
        end else begin
          w_state_next = RUN;
        end
      end
      default: w_state_next = FILL;
    endcase
  end

  // Pointers, count, host-side ready and FSM state.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr   <= ZERO;
      r_wr_ptr_d <= ZERO;
      r_rd_ptr   <= ZERO;
      r_count    <= ZERO;
      r_s_tready <= 1'b0;
      r_state    <= FILL;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + ONE;
      end
      r_wr_ptr_d <= r_wr_ptr;
      r_rd_ptr   <= w_rd_ptr_next;
      r_count    <= w_count_next;
      r_s_tready <= (w_count_next < DEPTH);
      r_state    <= w_state_next;
    end
  end

`ifdef AXIS_I2S_DAC_BUFFER_UNDERRUN_EN
  logic [31:0] r_underrun;

  // Saturating underrun event counter.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_underrun <= 32'd0;
    end else if (w_underrun && (r_underrun != 32'hFFFF_FFFF)) begin
      r_underrun <= r_underrun + 32'd1;
    end
  end

  assign sts_underrun = r_underrun;
`endif

  axis_i2s_dac_buffer_ram #(
    .DATA_WIDTH(AXIS_TDATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .i_clk    (aclk),
    .i_rst_n  (aresetn),
    .i_wr_en  (w_wr),
    .i_wr_addr(r_wr_ptr[ADDR_WIDTH-1:0]),
    .i_wr_data(s_axis_tdata),
    .i_rd_addr(w_rd_ptr_next[ADDR_WIDTH-1:0]),
    .o_rd_data(m_axis_tdata)
  );

endmodule

// File: tb/tb_axis_i2s_dac_buffer.sv
// Scoreboard bench for axis_i2s_dac_buffer: writes push expected samples, a monitor checks every pop.
module tb_axis_i2s_dac_buffer;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [9:0]  cfg_data = 10'd0;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata = 32'd0;
  logic        s_axis_tvalid = 1'b0;
  logic        m_axis_tready = 1'b0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic [9:0]  sts_data;
`ifdef AXIS_I2S_DAC_BUFFER_UNDERRUN_EN
  logic [31:0] sts_underrun;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  int          n_pops = 0;
  logic [31:0] q_exp[$];

  axis_i2s_dac_buffer dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .cfg_data     (cfg_data),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .sts_data     (sts_data)
`ifdef AXIS_I2S_DAC_BUFFER_UNDERRUN_EN
    ,
    .sts_underrun (sts_underrun)
`endif
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake is compared against the oldest expected sample.
  always @(negedge aclk) begin
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      if (q_exp.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pop: got 0x%08h, expected no output", m_axis_tdata);
      end else begin
        check("pop_data", m_axis_tdata, q_exp.pop_front());
      end
      n_pops++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic apply_reset();
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    aresetn = 1'b0;
    tick(2);
    aresetn = 1'b1;
    tick(1);
    q_exp.delete();
  endtask

  task automatic write_sample(input logic [31:0] d);
    bit done = 1'b0;
    int guard = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = d;
    while (!done && guard < 2000) begin
      @(negedge aclk);
      done = s_axis_tready;
      if (done) q_exp.push_back(d);
      @(posedge aclk);
      #1;
      guard++;
    end
    s_axis_tvalid = 1'b0;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL write_timeout: got no s_axis_tready, expected one within 2000 cycles");
    end
  endtask

  task automatic pulse_ready();
    m_axis_tready = 1'b1;
    tick(1);
    m_axis_tready = 1'b0;
  endtask

  task automatic write_and_pop(input logic [31:0] d);
    s_axis_tvalid = 1'b1;
    s_axis_tdata = d;
    m_axis_tready = 1'b1;
    @(negedge aclk);
    check("simul_tready", {31'd0, s_axis_tready}, 32'd1);
    if (s_axis_tready) q_exp.push_back(d);
    tick(1);
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
  endtask

  initial begin
    // Reset values, then ready from the first edge after release.
    tick(3);
    check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_tdata", m_axis_tdata, 32'd0);
    check("rst_sts", {22'd0, sts_data}, 32'd0);
    check("rst_tready", {31'd0, s_axis_tready}, 32'd0);
    aresetn = 1'b1;
    check("tready_before_edge", {31'd0, s_axis_tready}, 32'd0);
    tick(1);
    check("tready_after_edge", {31'd0, s_axis_tready}, 32'd1);

    // Prefill at level 4 with a ready pulse every 8 cycles.
    cfg_data = 10'd4;
    for (int i = 1; i <= 4; i++) begin
      write_sample({16'(i), 16'(i)});
      tick(6);
      check("prefill_tvalid", {31'd0, m_axis_tvalid}, (i < 4) ? 32'd0 : 32'd1);
      pulse_ready();
    end
    check("prefill_sts", {22'd0, sts_data}, 32'd3);
    for (int i = 0; i < 3; i++) begin
      tick(7);
      pulse_ready();
    end
    check("prefill_drained", {22'd0, sts_data}, 32'd0);

    // Full buffer with the prefill level clamped to the depth.
    apply_reset();
    cfg_data = 10'd600;
    for (int i = 0; i < 512; i++) write_sample(32'hA000_0000 + 32'(i));
    check("full_tready", {31'd0, s_axis_tready}, 32'd0);
    check("full_sts", {22'd0, sts_data}, 32'd512);
    tick(2);
    check("full_run_tvalid", {31'd0, m_axis_tvalid}, 32'd1);

    // Simultaneous write and pop at full, then again with one entry held.
    write_and_pop(32'h5555_0001);
    check("simul_full_sts", {22'd0, sts_data}, 32'd512);
    m_axis_tready = 1'b1;
    tick(511);
    m_axis_tready = 1'b0;
    check("drain_to_one_sts", {22'd0, sts_data}, 32'd1);
    write_and_pop(32'h5555_0002);
    check("simul_one_sts", {22'd0, sts_data}, 32'd1);
    tick(3);
    pulse_ready();
    check("simul_drained_sts", {22'd0, sts_data}, 32'd0);

    // Underrun: two pops succeed, the third request drops back to FILL.
    apply_reset();
    cfg_data = 10'd2;
    write_sample(32'h0B0B_0001);
    write_sample(32'h0B0B_0002);
    for (int i = 0; i < 3; i++) begin
      tick(3);
      pulse_ready();
    end
    check("underrun_pops", 32'(q_exp.size()), 32'd0);
`ifdef AXIS_I2S_DAC_BUFFER_UNDERRUN_EN
    check("underrun_count", sts_underrun, 32'd1);
`endif
    write_sample(32'h0B0B_0003);
    tick(4);
    check("underrun_fill_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("underrun_fill_sts", {22'd0, sts_data}, 32'd1);

    // Asynchronous reset with 100 samples buffered.
    apply_reset();
    cfg_data = 10'd50;
    for (int i = 0; i < 100; i++) write_sample(32'hC000_0000 + 32'(i));
    tick(2);
    check("pre_areset_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
    check("pre_areset_sts", {22'd0, sts_data}, 32'd100);
    #2;
    aresetn = 1'b0;
    #1;
    check("areset_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("areset_tdata", m_axis_tdata, 32'd0);
    check("areset_sts", {22'd0, sts_data}, 32'd0);
    check("areset_tready", {31'd0, s_axis_tready}, 32'd0);
    q_exp.delete();
    tick(1);
    aresetn = 1'b1;
    tick(1);
    check("post_areset_sts", {22'd0, sts_data}, 32'd0);
    check("post_areset_tready", {31'd0, s_axis_tready}, 32'd1);
    write_sample(32'hC0DE_0001);
    tick(4);
    check("post_areset_fill", {31'd0, m_axis_tvalid}, 32'd0);

    // Pointer wrap: 1500 samples streamed at level 256.
    apply_reset();
    cfg_data = 10'd256;
    n_pops = 0;
    fork
      begin
        for (int i = 0; i < 1500; i++) write_sample({16'(i), ~16'(i)});
      end
      begin
        bit toggle = 1'b0;
        int cyc = 0;
        while (n_pops < 1500 && cyc < 20000) begin
          m_axis_tready = m_axis_tvalid && !toggle;
          toggle = !toggle;
          tick(1);
          cyc++;
        end
        m_axis_tready = 1'b0;
      end
    join
    check("wrap_pops", 32'(n_pops), 32'd1500);
    check("wrap_left", 32'(q_exp.size()), 32'd0);
`ifdef AXIS_I2S_DAC_BUFFER_UNDERRUN_EN
    check("wrap_underruns", sts_underrun, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axis_i2s_dac_buffer.md
AXIS_I2S_DAC_BUFFER -- requirements
Module: axis_i2s_dac_buffer

Interface
REQ-001 SHALL have parameter AXIS_TDATA_WIDTH, default 32, stereo sample width (left in upper half, right in lower half).
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, log2 of buffer depth (512 samples).
REQ-003 SHALL have port aclk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port aresetn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port cfg_data  input  ADDR_WIDTH+1  prefill level, in samples.
REQ-006 SHALL have ports s_axis_tready out 1, s_axis_tdata in AXIS_TDATA_WIDTH, s_axis_tvalid in 1: host sample input, standard AXI4-Stream handshake.
REQ-007 SHALL have ports m_axis_tready in 1, m_axis_tdata out AXIS_TDATA_WIDTH, m_axis_tvalid out 1: feed to I2S DAC serializer; tready is a one-cycle pulse per LRCLK frame.
REQ-008 SHALL have port sts_data  output  ADDR_WIDTH+1  current fill count, 0..2^ADDR_WIDTH.

Function
REQ-009 SHALL store samples in a circular buffer of 2^ADDR_WIDTH entries, first-word-fall-through on the master side.
REQ-010 SHALL assert s_axis_tready whenever fill count < 2^ADDR_WIDTH; a write occurs on s_axis_tvalid & s_axis_tready.
REQ-011 SHALL run a two-state FSM: FILL (m_axis_tvalid=0) and RUN (m_axis_tvalid = fill count != 0).
REQ-012 SHALL move FILL->RUN on the cycle after fill count >= effective level; effective level = max(1, min(cfg_data, 2^ADDR_WIDTH)).
REQ-013 SHALL pop one sample on m_axis_tready & m_axis_tvalid, advancing the read pointer; m_axis_tdata shows the next sample no later than the following cycle.
REQ-014 SHALL treat m_axis_tready while in RUN with fill count = 0 as an underrun: no pop, FSM returns to FILL.
REQ-015 SHALL ignore m_axis_tready in FILL (downstream transmits zeros).
REQ-016 SHALL make a written sample visible on m_axis no earlier than 2 cycles after its write handshake.
REQ-017 SHALL leave fill count unchanged on a simultaneous write and pop, including when full or holding one entry.
REQ-018 SHALL wrap both pointers modulo 2^ADDR_WIDTH, distinguishing full from empty via an extra pointer bit.
REQ-019 SHALL sample cfg_data every cycle; changing it in RUN has no effect until the next FILL.

Reset
REQ-020 SHALL, on aresetn low, immediately clear pointers and fill count, enter FILL, and drive m_axis_tvalid=0, m_axis_tdata=0, sts_data=0, s_axis_tready=0.
REQ-021 SHALL drive s_axis_tready=1 from the first clock edge after aresetn deasserts.
REQ-022 SHALL discard buffered samples on reset mid-operation; buffer contents need not be cleared.

Configuration
REQ-023 SHALL, with AXIS_I2S_DAC_BUFFER_UNDERRUN_EN defined, add output sts_underrun (32 bits): counts REQ-014 events, saturates at 2^32-1, resets to 0.
REQ-024 SHALL, without AXIS_I2S_DAC_BUFFER_UNDERRUN_EN, omit the sts_underrun port and counter; all other behaviour is identical.

Structure
REQ-025 SHALL take FSM state encodings (FILL=0, RUN=1) and the stereo half-width constant I2S_DATA_WIDTH from shared package axis_i2s_pkg.
REQ-026 SHALL instantiate storage as sub-module axis_i2s_dac_buffer_ram: simple dual-port, one write port, one registered read port, same clock.

Verification
REQ-027 SHALL cover prefill: cfg_data=4, write 0x00010001..0x00040004 with tready pulses every 8 cycles -> m_axis_tvalid stays 0 until 4 stored, then 0x00010001 pops first.
REQ-028 SHALL cover full: cfg_data=600, write 512 samples with no reads -> s_axis_tready=0, sts_data=512, FSM enters RUN via clamp.
REQ-029 SHALL cover simultaneous write+pop at full and at count 1 -> sts_data unchanged (512, 1), data order preserved.
REQ-030 SHALL cover underrun: cfg_data=2, write 2, pulse tready 3 times -> two pops, third pulse gives FILL and sts_underrun=1 (macro on).
REQ-031 SHALL cover async reset mid-stream at count 100 -> outputs zero without a clock edge; after release sts_data=0 and FILL.
REQ-032 SHALL cover pointer wrap: 1500 samples streamed at level 256 -> output sequence equals input sequence, no underruns.
